// File: rtl/simple_uart_tx_fifo.sv
// Byte FIFO feeding simple_uart_tx: first write pulse 2 cycles after a push into an idle block, one byte in flight at a time.
// Backpressure: push_ready low while DEPTH bytes are stored; offers while full are dropped silently.
module simple_uart_tx_fifo_buf #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             srst,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_full   = (r_level == FULL_LVL);
    assign o_empty  = (r_level == '0);
    assign w_wr     = i_push_vld & ~o_full;
    assign w_rd     = i_pop & ~o_empty;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_level  = r_level;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

module simple_uart_tx_fifo #(
    parameter  int DEPTH       = 16,
    localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   srst,
    input  logic [7:0]             push_value,
    input  logic                   push_valid,
    output logic                   push_ready,
    output logic [LEVEL_WIDTH-1:0] fifo_level,
    output logic                   busy,
    output logic [7:0]             tx_value,
    output logic                   tx_value_write,
    input  logic                   tx_value_done
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_tx_value;
    logic       r_tx_value_write;
    logic [7:0] w_rd_dat;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;

    assign push_ready     = ~w_full;
    assign w_push         = push_valid & push_ready;
    assign w_pop          = (r_state == ST_IDLE) & ~w_empty;
    assign busy           = ~w_empty | (r_state != ST_IDLE);
    assign tx_value       = r_tx_value;
    assign tx_value_write = r_tx_value_write;

    simple_uart_tx_fifo_buf #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_buf (
        .clock      (clock),
        .srst       (srst),
        .i_push_vld (w_push),
        .i_push_dat (push_value),
        .i_pop      (w_pop),
        .o_rd_dat   (w_rd_dat),
        .o_level    (fifo_level),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Done pulses arriving outside WAIT_DONE fall through the case untouched.
    always_ff @(posedge clock) begin
        if (srst) begin
            r_state          <= ST_IDLE;
            r_tx_value       <= 8'h00;
            r_tx_value_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_value       <= w_rd_dat;
                        r_tx_value_write <= 1'b1;
                        r_state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_tx_value_write <= 1'b0;
                    r_state          <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_value_done) r_state <= ST_IDLE;
                end
                default: begin
                    r_tx_value_write <= 1'b0;
                    r_state          <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simple_uart_tx_fifo.sv
// Directed bench for simple_uart_tx_fifo with a transmitter model answering done a fixed delay after each write.
module tb_simple_uart_tx_fifo;
    localparam int DEPTH    = 16;
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int DONE_DLY = 20;

    logic          clock = 1'b0;
    logic          srst = 1'b1;
    logic [7:0]    push_value = 8'h00;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [LW-1:0] fifo_level;
    logic          busy;
    logic [7:0]    tx_value;
    logic          tx_value_write;
    logic          tx_value_done;

    logic auto_en = 1'b0;
    logic auto_done = 1'b0;
    logic manual_done = 1'b0;
    logic outstanding = 1'b0;
    logic prev_wr = 1'b0;
    int   dly_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    assign tx_value_done = auto_done | manual_done;

    always #5 clock = ~clock;

    simple_uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .srst           (srst),
        .push_value     (push_value),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .fifo_level     (fifo_level),
        .busy           (busy),
        .tx_value       (tx_value),
        .tx_value_write (tx_value_write),
        .tx_value_done  (tx_value_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        int guard;
        guard = 0;
        push_value = v;
        push_valid = 1'b1;
        while (!push_ready && guard < 2000) begin
            tick();
            guard++;
        end
        check_eq("push_accept_wait", 32'(push_ready), 32'd1);
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy && guard < 3000) begin
            tick();
            guard++;
        end
        check_eq(tag, 32'(busy), 32'd0);
        tick();
    endtask

    task automatic check_seq(input string tag);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // Transmitter model: records each write pulse and answers done DONE_DLY cycles later when enabled.
    always @(negedge clock) begin
        if (srst) begin
            outstanding = 1'b0;
            auto_done   = 1'b0;
            prev_wr     = 1'b0;
            dly_cnt     = 0;
        end else begin
            if (tx_value_done) outstanding = 1'b0;
            auto_done = 1'b0;
            if (tx_value_write) begin
                check_eq("wr_pulse_single_cycle", 32'(prev_wr), 32'd0);
                if (!prev_wr) begin
                    check_eq("one_outstanding", 32'(outstanding), 32'd0);
                    got_q.push_back(tx_value);
                    outstanding = 1'b1;
                    dly_cnt     = 0;
                end
            end else if (auto_en && outstanding) begin
                dly_cnt++;
                if (dly_cnt == DONE_DLY) auto_done = 1'b1;
            end
            prev_wr = tx_value_write;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick();
        tick();
        check_eq("rst_push_ready", 32'(push_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_write", 32'(tx_value_write), 32'd0);
        check_eq("rst_tx_value", 32'(tx_value), 32'h00);
        srst = 1'b0;
        tick();

        // Single byte: write pulse 2 cycles after push, busy clears the cycle after done
        got_q.delete();
        push_value = 8'hA5;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        check_eq("t1_level_after_push", 32'(fifo_level), 32'd1);
        check_eq("t1_no_write_yet", 32'(tx_value_write), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        tick();
        check_eq("t1_write_high", 32'(tx_value_write), 32'd1);
        check_eq("t1_tx_value", 32'(tx_value), 32'hA5);
        check_eq("t1_level_after_pop", 32'(fifo_level), 32'd0);
        tick();
        check_eq("t1_write_low", 32'(tx_value_write), 32'd0);
        check_eq("t1_tx_value_held", 32'(tx_value), 32'hA5);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t1_busy_waiting", 32'(busy), 32'd1);
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        check_eq("t1_busy_after_done", 32'(busy), 32'd0);
        tick();

        // Five back-to-back bytes with the auto transmitter
        got_q.delete();
        exp_q.delete();
        auto_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        wait_idle("t2_drain");
        check_seq("t2_seq");

        // Fill with transmitter stalled; a push while full is dropped
        auto_en = 1'b0;
        got_q.delete();
        exp_q.delete();
        push_byte(8'h10);
        exp_q.push_back(8'h10);
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < DEPTH; i++) begin
            push_byte(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        check_eq("t3_level_full", 32'(fifo_level), 32'd16);
        check_eq("t3_ready_low", 32'(push_ready), 32'd0);
        push_value = 8'hFF;
        push_valid = 1'b1;
        tick();
        tick();
        push_valid = 1'b0;
        check_eq("t3_level_after_drop", 32'(fifo_level), 32'd16);
        auto_en = 1'b1;
        wait_idle("t3_drain");
        check_seq("t3_seq");

        // Simultaneous push and pop at level 3
        auto_en = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int i = 1; i <= 4; i++) begin
            push_byte(8'h30 + 8'(i));
            exp_q.push_back(8'h30 + 8'(i));
        end
        tick();
        tick();
        check_eq("t4_level_pre", 32'(fifo_level), 32'd3);
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        push_value = 8'h35;
        push_valid = 1'b1;
        exp_q.push_back(8'h35);
        tick();
        push_valid = 1'b0;
        check_eq("t4_level_push_pop", 32'(fifo_level), 32'd3);
        check_eq("t4_write_on_pop", 32'(tx_value_write), 32'd1);
        check_eq("t4_tx_value", 32'(tx_value), 32'h32);
        auto_en = 1'b1;
        wait_idle("t4_drain");
        check_seq("t4_seq");

        // 40 bytes through the pointers, wrapping more than twice
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            push_byte(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        wait_idle("t5_drain");
        check_seq("t5_seq");

        // Reset in WAIT_DONE with 4 queued
        auto_en = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
        tick();
        tick();
        check_eq("t6_level_pre", 32'(fifo_level), 32'd4);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        got_q.delete();
        check_eq("t6_level_rst", 32'(fifo_level), 32'd0);
        check_eq("t6_busy_rst", 32'(busy), 32'd0);
        check_eq("t6_write_rst", 32'(tx_value_write), 32'd0);
        check_eq("t6_ready_rst", 32'(push_ready), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_no_writes", 32'(got_q.size()), 32'd0);

        // Spurious done in IDLE, then normal issue latency still holds
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        check_eq("t7_write", 32'(tx_value_write), 32'd0);
        check_eq("t7_busy", 32'(busy), 32'd0);
        tick();
        check_eq("t7_write_later", 32'(tx_value_write), 32'd0);
        push_value = 8'h5A;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        check_eq("t7_no_write_yet", 32'(tx_value_write), 32'd0);
        tick();
        check_eq("t7_write_high", 32'(tx_value_write), 32'd1);
        check_eq("t7_tx_value", 32'(tx_value), 32'h5A);
        auto_en = 1'b1;
        wait_idle("t7_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
